// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the digit-serial subtractor.
// Holds the FSM state encoding, default widths and the counter width helper.
package serial_sub_pkg;

    localparam int unsigned SUB_WIDTH_DEF = 32;
    localparam int unsigned SUB_DIGIT_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sub_state_e;

    // Digit counter width; a single-digit operation still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        if (n <= 32'd1) begin
            return 32'd1;
        end
        return 32'($clog2(n));
    endfunction

endpackage

// File: rtl/serial_subtractor_digit.sv
// Combinational DIGIT-bit ripple-borrow subtractor slice: d = a - b - bin.
// One per-bit borrow cell per bit, chained LSB to MSB.
module digit_subtractor #(
    parameter int unsigned DIGIT = 8
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             bin,
    output logic [DIGIT-1:0] d,
    output logic             bout
);

    logic [DIGIT:0] br;

    always_comb begin
        br    = '0;
        d     = '0;
        br[0] = bin;
        for (int i = 0; i < int'(DIGIT); i++) begin
            d[i]    = a[i] ^ b[i] ^ br[i];
            br[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
        end
    end

    assign bout = br[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, DIGIT bits per clock, valid/ready on both sides.
// Define SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = SUB_WIDTH_DEF,
    parameter int unsigned DIGIT = SUB_DIGIT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
`ifdef SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NUM_DIGITS = WIDTH / DIGIT;
    localparam int unsigned CW         = cnt_width(NUM_DIGITS);

    if ((DIGIT < 32'd1) || (DIGIT > WIDTH)) begin : g_bad_digit
        $fatal(1, "serial_subtractor: DIGIT must satisfy 1 <= DIGIT <= WIDTH");
    end
    if ((WIDTH % DIGIT) != 32'd0) begin : g_bad_ratio
        $fatal(1, "serial_subtractor: WIDTH must be a multiple of DIGIT");
    end

    sub_state_e       state_q;
    sub_state_e       state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] res_q;
    logic             br_q;

    logic [DIGIT-1:0] dig_d;
    logic             dig_bout;
    logic [WIDTH-1:0] res_step;
    logic             last;
    logic             accept;
    logic             step;
    logic             finish;

    digit_subtractor #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a    (a_sh_q[DIGIT-1:0]),
        .b    (b_sh_q[DIGIT-1:0]),
        .bin  (br_q),
        .d    (dig_d),
        .bout (dig_bout)
    );

    // New digit enters at the top so the LSB digit ends up at bit 0 after NUM_DIGITS steps.
    assign res_step = (res_q >> DIGIT) | (WIDTH'(dig_d) << (WIDTH - DIGIT));
    assign last     = (cnt_q == CW'(NUM_DIGITS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                step = 1'b1;
                if (last) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand shifters, running borrow, partial result and digit counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh_q <= '0;
            b_sh_q <= '0;
            res_q  <= '0;
            br_q   <= 1'b0;
            cnt_q  <= '0;
        end else if (accept) begin
            a_sh_q <= a;
            b_sh_q <= b;
            res_q  <= '0;
            br_q   <= bin;
            cnt_q  <= '0;
        end else if (step) begin
            a_sh_q <= a_sh_q >> DIGIT;
            b_sh_q <= b_sh_q >> DIGIT;
            res_q  <= res_step;
            br_q   <= dig_bout;
            cnt_q  <= cnt_q + CW'(1);
        end
    end

    // Handshake flags and result outputs; results load only when the last digit completes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            zero      <= 1'b0;
        end else begin
            in_ready <= (state_d == IDLE);
            if (finish) begin
                out_valid <= 1'b1;
                diff      <= res_step;
                bout      <= dig_bout;
                zero      <= (res_step == '0);
            end else if ((state_q == DONE) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef SUB_OVF_EN
    logic a_msb_q;
    logic b_msb_q;

    // Operand signs are kept from accept since the shifters discard them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            if (accept) begin
                a_msb_q <= a[WIDTH-1];
                b_msb_q <= b[WIDTH-1];
            end
            if (finish) begin
                ovf <= (a_msb_q != b_msb_q) && (res_step[WIDTH-1] != a_msb_q);
            end
        end
    end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: DIGIT=8 and DIGIT=WIDTH instances share stimulus.
// Checks ovf as well when SUB_OVF_EN is defined.
module tb_serial_subtractor;

    localparam int unsigned W  = 32;
    localparam int unsigned D0 = 8;
    localparam int unsigned N0 = W / D0;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         zero;
        logic         ovf;
    } exp_t;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b0;
    logic         bin       = 1'b0;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;

    logic         in_ready0, out_valid0, bout0, zero0;
    logic         in_ready1, out_valid1, bout1, zero1;
    logic [W-1:0] diff0, diff1;
`ifdef SUB_OVF_EN
    logic         ovf0, ovf1;
`endif

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W), .DIGIT(D0)) u_dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready0),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid0),
        .out_ready (out_ready),
        .diff      (diff0),
        .bout      (bout0),
        .zero      (zero0)
`ifdef SUB_OVF_EN
        ,
        .ovf       (ovf0)
`endif
    );

    serial_subtractor #(.WIDTH(W), .DIGIT(W)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .diff      (diff1),
        .bout      (bout1),
        .zero      (zero1)
`ifdef SUB_OVF_EN
        ,
        .ovf       (ovf1)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one operation, hold the result for 'stall' cycles, then complete the handshake.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tbin, input int stall);
        exp_t         e;
        exp_t         got_e;
        logic [W:0]   full;
        logic [W-1:0] hold0;
        logic         holdb;
        int           c0;
        int           c1;
        int           n;

        full   = {1'b0, ta} - {1'b0, tb_v} - (W+1)'(tbin);
        e.diff = full[W-1:0];
        e.bout = full[W];
        e.zero = (full[W-1:0] == '0);
        e.ovf  = (ta[W-1] != tb_v[W-1]) && (full[W-1] != ta[W-1]);

        n = 0;
        while (!(in_ready0 && in_ready1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_idle", 64'({in_ready0, in_ready1}), 64'(2'b11));

        a        = ta;
        b        = tb_v;
        bin      = tbin;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        bin      = 1'b0;
        sb.push_back(e);

        c0 = -1;
        c1 = -1;
        for (int k = 0; k < 100 && (c0 < 0 || c1 < 0); k++) begin
            @(negedge clk);
            if (k == 0) begin
                check("in_ready_busy", 64'({in_ready0, in_ready1}), 64'(2'b00));
            end
            if (out_valid0 && c0 < 0) c0 = k;
            if (out_valid1 && c1 < 0) c1 = k;
        end
        check("latency_d8", 64'(c0), 64'(N0));
        check("latency_d32", 64'(c1), 64'(1));

        hold0 = diff0;
        holdb = bout0;
        for (int s = 0; s < stall; s++) begin
            in_valid = s[0];
            a        = $urandom;
            b        = $urandom;
            @(negedge clk);
            check("stall_valid", 64'({out_valid0, out_valid1}), 64'(2'b11));
            check("stall_diff", 64'(diff0), 64'(hold0));
            check("stall_bout", 64'(bout0), 64'(holdb));
            check("stall_in_ready", 64'({in_ready0, in_ready1}), 64'(2'b00));
        end
        in_valid = 1'b0;

        if (sb.size() > 0) begin
            got_e = sb.pop_front();
            check("diff_d8", 64'(diff0), 64'(got_e.diff));
            check("bout_d8", 64'(bout0), 64'(got_e.bout));
            check("zero_d8", 64'(zero0), 64'(got_e.zero));
            check("diff_d32", 64'(diff1), 64'(got_e.diff));
            check("bout_d32", 64'(bout1), 64'(got_e.bout));
            check("zero_d32", 64'(zero1), 64'(got_e.zero));
`ifdef SUB_OVF_EN
            check("ovf_d8", 64'(ovf0), 64'(got_e.ovf));
            check("ovf_d32", 64'(ovf1), 64'(got_e.ovf));
`endif
        end else begin
            check("sb_underflow", 64'(sb.size()), 64'(1));
        end

        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("post_hs_valid", 64'({out_valid0, out_valid1}), 64'(2'b00));
        check("post_hs_in_ready", 64'({in_ready0, in_ready1}), 64'(2'b11));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'({in_ready0, in_ready1}), 64'(2'b00));
        check("rst_out_valid", 64'({out_valid0, out_valid1}), 64'(2'b00));
        check("rst_diff", 64'(diff0), 64'(0));
        check("rst_bout_zero", 64'({bout0, zero0}), 64'(0));
`ifdef SUB_OVF_EN
        check("rst_ovf", 64'({ovf0, ovf1}), 64'(0));
`endif
        rst_n = 1'b1;
        @(negedge clk);
        check("first_in_ready", 64'({in_ready0, in_ready1}), 64'(2'b11));

        run_op(32'h0000_0005, 32'h0000_0003, 1'b0, 0);
        run_op(32'h0000_0000, 32'h0000_0001, 1'b0, 0);
        run_op(32'h0000_0100, 32'h0000_00FF, 1'b1, 0);
        run_op(32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 5);
        run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1);
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        run_op(32'h0000_0000, 32'h0000_0000, 1'b0, 2);

        // Abort an operation in its second BUSY cycle.
        a        = 32'h1234_5678;
        b        = 32'h0000_0001;
        bin      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_out_valid", 64'({out_valid0, out_valid1}), 64'(2'b00));
        check("abort_diff", 64'(diff0), 64'(0));
        check("abort_in_ready", 64'({in_ready0, in_ready1}), 64'(2'b00));
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("abort_no_output", 64'(out_valid0), 64'(0));
        end
        run_op(32'd9, 32'd4, 1'b0, 0);

        for (int r = 0; r < 6; r++) begin
            run_op($urandom, $urandom, 1'($urandom_range(0, 1)), r % 3);
        end

        check("sb_empty", 64'(sb.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
